// File: rtl/fetch_line_buffer_if.sv
// Fetch line buffer bus bundle: redirect input, Muskbus line-reader request/response
// and the beat output stream toward the decoder.
interface fetch_line_buffer_if #(
  parameter int OUT_BYTES = 8
);
  logic                     redirect;
  logic [63:0]              redirect_pc;
  logic                     rd_reqcyc;
  logic [63:0]              rd_addr;
  logic                     rd_respcyc;
  logic [0:511]             rd_data;
  logic                     out_valid;
  logic [63:0]              out_pc;
  logic [0:8*OUT_BYTES-1]   out_data;
  logic                     out_ready;

  // master: the line buffer itself; slave: the reader/consumer/redirect environment
  modport master (
    input  redirect, redirect_pc, rd_respcyc, rd_data, out_ready,
    output rd_reqcyc, rd_addr, out_valid, out_pc, out_data
  );
  modport slave (
    output redirect, redirect_pc, rd_respcyc, rd_data, out_ready,
    input  rd_reqcyc, rd_addr, out_valid, out_pc, out_data
  );
endinterface

// File: rtl/fetch_line_buffer.sv
// Two-slot instruction fetch line buffer: demand-fetches the redirect line, prefetches
// the next sequential line, and drains the current line as OUT_BYTES-wide beats.
module flb_byte_sel (
  input  logic [0:511] i_line,
  input  logic [5:0]   i_idx,
  output logic [7:0]   o_byte
);
  assign o_byte = i_line[{i_idx, 3'b000} +: 8];
endmodule

module fetch_line_buffer #(
  parameter int OUT_BYTES = 8
) (
  input  logic            clk,
  input  logic            reset,
  fetch_line_buffer_if.master bus
);
  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

  localparam logic [63:0] PC_MASK   = ~(64'(OUT_BYTES) - 64'd1);
  localparam logic [63:0] LINE_MASK = ~64'd63;
  localparam logic [5:0]  LAST_OFF  = 6'(64 - OUT_BYTES);

  state_t            r_state, w_state_nxt;
  logic [63:0]       r_pc, w_pc_nxt;
  logic              r_cur, w_cur_nxt;
  logic [1:0]        r_valid, w_valid_nxt;
  logic [1:0][63:0]  r_tag, w_tag_nxt;
  logic              r_outst, w_outst_nxt;
  logic              r_stale, w_stale_nxt;
  logic              r_tgt, w_tgt_nxt;
  logic              r_reqcyc, w_reqcyc_nxt;
  logic [63:0]       r_rd_addr, w_rd_addr_nxt;
  logic [0:511]      r_line [2];
  logic              w_fill, w_hs, w_eol;
  logic [0:8*OUT_BYTES-1] w_beat;

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_cur_nxt     = r_cur;
    w_valid_nxt   = r_valid;
    w_tag_nxt     = r_tag;
    w_outst_nxt   = r_outst;
    w_stale_nxt   = r_stale;
    w_tgt_nxt     = r_tgt;
    w_reqcyc_nxt  = 1'b0;
    w_rd_addr_nxt = r_rd_addr;
    w_fill        = 1'b0;
    w_hs          = (r_state == RUN) && bus.out_ready;
    w_eol         = (r_pc[5:0] == LAST_OFF);

    // A same-cycle redirect makes the arriving line stale as well
    if (bus.rd_respcyc && r_outst) begin
      w_outst_nxt = 1'b0;
      w_stale_nxt = 1'b0;
      if (!r_stale && !bus.redirect) begin
        w_fill               = 1'b1;
        w_valid_nxt[r_tgt]   = 1'b1;
      end
    end

    if (bus.redirect) begin
      w_valid_nxt        = 2'b00;
      w_pc_nxt           = bus.redirect_pc & PC_MASK;
      w_tag_nxt[r_cur]   = bus.redirect_pc & LINE_MASK;
      w_stale_nxt        = w_outst_nxt;
      w_state_nxt        = FILL;
    end else if (w_hs) begin
      w_pc_nxt = r_pc + 64'(OUT_BYTES);
      if (w_eol) begin
        w_valid_nxt[r_cur] = 1'b0;
        w_cur_nxt          = ~r_cur;
        w_tag_nxt[~r_cur]  = r_tag[r_cur] + 64'd64;
      end
    end

    if (w_state_nxt != IDLE)
      w_state_nxt = w_valid_nxt[w_cur_nxt] ? RUN : FILL;

    // Issue decisions look at post-update state so a request can follow a response directly
    if (w_state_nxt != IDLE && !w_outst_nxt) begin
      if (!w_valid_nxt[w_cur_nxt]) begin
        w_reqcyc_nxt  = 1'b1;
        w_outst_nxt   = 1'b1;
        w_tgt_nxt     = w_cur_nxt;
        w_rd_addr_nxt = w_tag_nxt[w_cur_nxt];
      end else if (!w_valid_nxt[~w_cur_nxt]) begin
        w_reqcyc_nxt            = 1'b1;
        w_outst_nxt             = 1'b1;
        w_tgt_nxt               = ~w_cur_nxt;
        w_rd_addr_nxt           = w_tag_nxt[w_cur_nxt] + 64'd64;
        w_tag_nxt[~w_cur_nxt]   = w_tag_nxt[w_cur_nxt] + 64'd64;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_pc      <= '0;
      r_cur     <= 1'b0;
      r_valid   <= 2'b00;
      r_tag     <= '0;
      r_outst   <= 1'b0;
      r_stale   <= 1'b0;
      r_tgt     <= 1'b0;
      r_reqcyc  <= 1'b0;
      r_rd_addr <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_cur     <= w_cur_nxt;
      r_valid   <= w_valid_nxt;
      r_tag     <= w_tag_nxt;
      r_outst   <= w_outst_nxt;
      r_stale   <= w_stale_nxt;
      r_tgt     <= w_tgt_nxt;
      r_reqcyc  <= w_reqcyc_nxt;
      r_rd_addr <= w_rd_addr_nxt;
    end
  end

  // Line storage carries no reset; the slot valid bits gate every use of it
  always_ff @(posedge clk) begin
    if (w_fill) r_line[r_tgt] <= bus.rd_data;
  end

  for (genvar k = 0; k < OUT_BYTES; k++) begin : g_byte
    flb_byte_sel u_sel (
      .i_line (r_line[r_cur]),
      .i_idx  (r_pc[5:0] + 6'(k)),
      .o_byte (w_beat[8*k +: 8])
    );
  end

  assign bus.rd_reqcyc = r_reqcyc;
  assign bus.rd_addr   = r_rd_addr;
  assign bus.out_valid = (r_state == RUN);
  assign bus.out_pc    = r_pc;
  assign bus.out_data  = (r_state == RUN) ? w_beat : '0;
endmodule

// File: doc/fetch_line_buffer.md
FETCH_LINE_BUFFER -- requirements
Module: fetch_line_buffer

Interface
REQ-001 SHALL have parameter OUT_BYTES, default 8, bytes per output beat; legal values 1, 2, 4, 8.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1; reset is synchronous and active-low (asserted when 0, sampled on clk).
REQ-004 SHALL have port redirect, input, 1, restart fetch at redirect_pc.
REQ-005 SHALL have port redirect_pc, input, 64, new fetch byte address.
REQ-006 SHALL have port rd_reqcyc, output, 1, line-read request to the Muskbus line reader.
REQ-007 SHALL have port rd_addr, output, 64, line-aligned read address (bits 5:0 always 0).
REQ-008 SHALL have port rd_respcyc, input, 1, one-cycle line-delivered strobe from the reader.
REQ-009 SHALL have port rd_data, input, 512 ([0:511]), line; byte k at bits [8k +: 8].
REQ-010 SHALL have port out_valid, output, 1, beat available.
REQ-011 SHALL have port out_pc, output, 64, byte address of the beat's first byte.
REQ-012 SHALL have port out_data, output, 8*OUT_BYTES ([0:8*OUT_BYTES-1]), byte k = memory byte out_pc+k.
REQ-013 SHALL have port out_ready, input, 1, consumer accepts beat when out_valid && out_ready.

Function
REQ-014 SHALL hold two 64-byte line slots, each with valid bit and 64-bit line tag; a current-slot pointer selects the slot being drained.
REQ-015 SHALL implement states IDLE (no fetch target; from reset), FILL (current slot awaiting data), RUN (current slot valid); redirect from any state -> FILL.
REQ-016 SHALL on redirect invalidate both slots, set fetch pc = redirect_pc with low log2(OUT_BYTES) bits cleared, and target current slot at line pc & ~63.
REQ-017 SHALL assert rd_reqcyc for exactly one cycle per request and hold rd_addr stable from that cycle through the matching rd_respcyc cycle.
REQ-018 SHALL keep at most one request outstanding and issue no request before the cycle after the previous rd_respcyc.
REQ-019 SHALL issue the demand request for a redirect in cycle t+1 of a redirect at cycle t if no request is outstanding.
REQ-020 SHALL on rd_respcyc for a non-stale request write rd_data into the target slot and set it valid; out_valid rises the following cycle if that slot is current.
REQ-021 SHALL prefetch line tag+64 (modulo 2^64) into the other slot when the current slot is valid, the other slot invalid, and no request outstanding.
REQ-022 SHALL drive out_valid = current slot valid in RUN; out_data = bytes [pc&63, pc&63+OUT_BYTES) of current slot; out_pc = pc.
REQ-023 SHALL on handshake advance pc by OUT_BYTES modulo 2^64; when the consumed beat ends the line, invalidate current slot and swap pointer.
REQ-024 SHALL hold out_valid, out_pc, out_data stable while out_valid && !out_ready.
REQ-025 SHALL, on redirect with a request outstanding, mark it stale, discard its rd_respcyc, and issue the new demand request the cycle after that response.
REQ-026 SHALL give redirect priority over a same-cycle handshake (beat dropped, pc from redirect_pc) and treat a same-cycle rd_respcyc as stale.
REQ-027 SHALL accept back-to-back redirects; only the last sampled redirect_pc determines output.

Reset
REQ-028 SHALL while reset==0 force state IDLE, both slots invalid, no request outstanding, stale clear, pointer 0, pc 0.
REQ-029 SHALL drive rd_reqcyc=0, rd_addr=0, out_valid=0, out_pc=0, out_data=0 during and after reset until the first redirect.
REQ-030 SHALL rely on the line reader sharing the same reset; reset mid-fill abandons the request with no response expected.

Verification
REQ-031 Reset, redirect 0x1000 at t, reader answers 10 cycles later with byte k=k -> rd_reqcyc one cycle at t+1, addr 0x1000; 8 beats pc 0x1000..0x1038, first out_data bytes 00..07.
REQ-032 Same, out_ready=1 -> prefetch rd_reqcyc addr 0x1040 the cycle after first rd_respcyc; beat 9 pc 0x1040 follows beat 8 with no bubble once line 2 filled.
REQ-033 out_ready=0 for 20 cycles mid-line -> out_valid=1, out_pc, out_data unchanged throughout.
REQ-034 Redirect 0x2000 while 0x1000 fill outstanding -> 0x1000 response discarded; rd_reqcyc addr 0x2000 next cycle; first out_pc 0x2000.
REQ-035 Redirect 0x1004 with OUT_BYTES=8 -> first out_pc 0x1000; redirect 0xFFFFFFFFFFFFFFC0 -> prefetch rd_addr 0x0.
REQ-036 Redirect in same cycle as handshake and rd_respcyc -> beat not re-presented, response discarded, next out_pc = new redirect_pc.
